// File: rtl/i2c_master_tx_if.sv
// Host-side request/status bundle for the I2C write master.
// The host (master modport) issues start_tx with a payload; the engine (slave modport) reports status.
interface i2c_master_tx_if #(
  parameter int DATA_BYTES = 33
);
  logic                    start_tx;
  logic [8*DATA_BYTES-1:0] data_in;
  logic                    busy;
  logic                    done;
  logic                    nack_err;
  logic [5:0]              byte_cnt;

  modport master (output start_tx, data_in, input busy, done, nack_err, byte_cnt);
  modport slave  (input start_tx, data_in, output busy, done, nack_err, byte_cnt);
endinterface

// File: rtl/i2c_master_tx.sv
// I2C write-only master: START, {addr,W}, DATA_BYTES payload bytes, STOP; done (2+9*(DATA_BYTES+1))*4*QUARTER clk after accept.
// No backpressure: start_tx is taken only in IDLE and ignored while busy; a NACK aborts straight to STOP.
module i2c_master_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h6A,
  parameter int         DATA_BYTES = 33,
  parameter int         QUARTER    = 5
) (
  input  logic           i_clk,
  input  logic           i_reset,
  i2c_master_tx_if.slave host,
  output logic           o_scl,
  inout  wire            io_sda
);

  localparam int         W         = 8 * DATA_BYTES;
  localparam int         QW        = (QUARTER > 1) ? $clog2(QUARTER) : 1;
  localparam logic [7:0] ADDR_BYTE = {SLAVE_ADDR, 1'b0};
  localparam logic [5:0] BC_MAX    = 6'(DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_STOP
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [QW-1:0]   r_qcnt;
  logic [1:0]      r_quarter;
  logic [2:0]      r_bit;
  logic [W-1:0]    r_shift;
  logic            r_ack;
  logic            r_busy;
  logic            r_done;
  logic            r_nack;
  logic [5:0]      r_byte_cnt;

  logic            w_qend;
  logic            w_bit_end;
  logic            w_accept;
  logic            w_ack_state;
  logic            w_scl;
  logic            w_sda_low;

  assign w_qend      = (r_qcnt == QW'(QUARTER - 1));
  assign w_bit_end   = w_qend && (r_quarter == 2'd3);
  assign w_accept    = (r_state == S_IDLE) && host.start_tx;
  assign w_ack_state = (r_state == S_ADDR_ACK) || (r_state == S_DATA_ACK);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (w_accept) w_next = S_START;
      S_START:    if (w_bit_end) w_next = S_ADDR;
      S_ADDR:     if (w_bit_end && (r_bit == 3'd7)) w_next = S_ADDR_ACK;
      S_ADDR_ACK: if (w_bit_end) w_next = r_ack ? S_DATA : S_STOP;
      S_DATA:     if (w_bit_end && (r_bit == 3'd7)) w_next = S_DATA_ACK;
      S_DATA_ACK: if (w_bit_end) w_next = (!r_ack || (r_byte_cnt + 6'd1 == BC_MAX)) ? S_STOP : S_DATA;
      S_STOP:     if (w_bit_end) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  // Bus levels decode straight from state/quarter: scl low in q0-q1, high in q2-q3 of every bit.
  always_comb begin
    w_scl     = 1'b1;
    w_sda_low = 1'b0;
    case (r_state)
      S_START: begin
        w_scl     = (r_quarter != 2'd3);
        w_sda_low = (r_quarter != 2'd0);
      end
      S_ADDR: begin
        w_scl     = r_quarter[1];
        w_sda_low = !ADDR_BYTE[3'd7 - r_bit];
      end
      S_DATA: begin
        w_scl     = r_quarter[1];
        w_sda_low = !r_shift[W-1];
      end
      S_ADDR_ACK, S_DATA_ACK: w_scl = r_quarter[1];
      S_STOP: begin
        w_scl     = (r_quarter != 2'd0);
        w_sda_low = !r_quarter[1];
      end
      default: ;
    endcase
  end

  assign o_scl  = w_scl;
  assign io_sda = w_sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_qcnt    <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
    end else if (r_state == S_IDLE) begin
      r_qcnt    <= '0;
      r_quarter <= '0;
      r_bit     <= '0;
    end else begin
      r_qcnt <= w_qend ? '0 : r_qcnt + 1'b1;
      if (w_qend) r_quarter <= r_quarter + 2'd1;
      if (w_bit_end && ((r_state == S_ADDR) || (r_state == S_DATA))) r_bit <= r_bit + 3'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_shift    <= '0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_nack     <= 1'b0;
      r_byte_cnt <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_shift    <= host.data_in;
        r_busy     <= 1'b1;
        r_nack     <= 1'b0;
        r_byte_cnt <= '0;
      end
      // Slave answer is taken on the last clk of q2, mid-way through scl high.
      if (w_ack_state && w_qend && (r_quarter == 2'd2)) r_ack <= (io_sda == 1'b0);
      if (w_bit_end) begin
        case (r_state)
          S_DATA:     r_shift <= {r_shift[W-2:0], 1'b0};
          S_ADDR_ACK: if (!r_ack) r_nack <= 1'b1;
          S_DATA_ACK: begin
            if (!r_ack)                     r_nack     <= 1'b1;
            else if (r_byte_cnt != BC_MAX)  r_byte_cnt <= r_byte_cnt + 6'd1;
          end
          S_STOP: begin
            r_busy <= 1'b0;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign host.busy     = r_busy;
  assign host.done     = r_done;
  assign host.nack_err = r_nack;
  assign host.byte_cnt = r_byte_cnt;

endmodule

// File: tb/tb_i2c_master_tx.sv
// Directed bench for i2c_master_tx: bus monitor with ACKing slave model, latency, status and framing checks.
module tb_i2c_master_tx;
  localparam int DB  = 33;
  localparam int Q   = 5;
  localparam int BIT = 4 * Q;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  i2c_master_tx_if #(.DATA_BYTES(DB)) bus ();
  wire scl;
  wire sda;
  logic slv_low = 1'b0;
  pullup pu_sda (sda);
  assign sda = slv_low ? 1'b0 : 1'bz;

  i2c_master_tx #(.SLAVE_ADDR(7'h6A), .DATA_BYTES(DB), .QUARTER(Q)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .host    (bus),
    .o_scl   (scl),
    .io_sda  (sda)
  );

  int checks = 0;
  int failures = 0;
  int nack_frame = -1;

  int bit_idx = 0, start_cnt = 0, stop_cnt = 0, timing_bad = 0;
  int high_len = 0, low_len = 0, run = 0;
  logic pscl = 1'b1, psda = 1'b1;
  logic [7:0] cur = '0;
  logic [7:0] rx[$];

  // Bus monitor and slave: samples on the falling clk edge, ACKs the 9th bit of each frame.
  always @(negedge clk) begin
    if (rst) begin
      slv_low = 1'b0;
      bit_idx = 0;
      run     = 0;
    end else begin
      if (pscl && scl && (sda !== psda)) begin
        if (!sda) begin start_cnt++; bit_idx = 0; end
        else stop_cnt++;
      end
      if (scl === pscl) run++;
      else begin
        if (pscl) high_len = run; else low_len = run;
        run = 1;
      end
      if (!pscl && scl) begin
        if (bit_idx % 9 < 8) begin
          cur = {cur[6:0], sda};
          if (bit_idx % 9 == 7) rx.push_back(cur);
        end
        bit_idx++;
      end
      if (pscl && !scl) begin
        if (bit_idx >= 1 && high_len != 2*Q) timing_bad++;
        if (bit_idx >= 2 && low_len != 2*Q) timing_bad++;
        if (bit_idx % 9 == 8) slv_low = ((bit_idx / 9) != nack_frame);
        else slv_low = 1'b0;
      end
    end
    pscl = scl;
    psda = sda;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [8*DB-1:0] d);
    @(negedge clk);
    bus.data_in  = d;
    bus.start_tx = 1'b1;
    @(posedge clk);
    #1;
    bus.start_tx = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!bus.done && lat < 8000);
  endtask

  logic [8*DB-1:0] d2, da, dbv;
  int lat, s0, p0, b0, t0;

  initial begin
    d2 = 264'h00112233445566778899AABBCCDDEEFF_0123456789ABCDEF0123456789ABCDEF_00;
    for (int k = 0; k < DB; k++) da[8*(DB-1-k) +: 8] = 8'(k * 7 + 3);
    dbv = ~da;
    rst = 1'b1;
    bus.start_tx = 1'b0;
    bus.data_in  = '0;
    #12;
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_nack", bus.nack_err, 0);
    chk("rst_byte_cnt", bus.byte_cnt, 0);
    @(negedge clk);
    rst = 1'b0;

    // Full ACKed write with default payload
    s0 = start_cnt; p0 = stop_cnt; b0 = rx.size(); t0 = timing_bad;
    launch(d2);
    chk("t2_busy", bus.busy, 1);
    wait_done(lat);
    chk("t2_latency", lat, 6160);
    chk("t2_byte_cnt", bus.byte_cnt, 33);
    chk("t2_nack", bus.nack_err, 0);
    chk("t2_busy_end", bus.busy, 0);
    @(posedge clk);
    #1;
    chk("t2_done_pulse", bus.done, 0);
    chk("t2_rx_count", rx.size() - b0, 34);
    chk("t2_addr_byte", rx[b0], 8'hD4);
    for (int k = 0; k < DB; k++) chk($sformatf("t2_byte%0d", k), rx[b0+1+k], d2[8*(DB-1-k) +: 8]);
    chk("t2_starts", start_cnt - s0, 1);
    chk("t2_stops", stop_cnt - p0, 1);
    chk("t6_scl_timing", timing_bad - t0, 0);

    // Address NACK
    nack_frame = 0;
    p0 = stop_cnt; b0 = rx.size();
    launch(d2);
    wait_done(lat);
    chk("t3_latency", lat, 11*BIT);
    chk("t3_nack", bus.nack_err, 1);
    chk("t3_byte_cnt", bus.byte_cnt, 0);
    chk("t3_stops", stop_cnt - p0, 1);
    chk("t3_rx_count", rx.size() - b0, 1);

    // NACK on payload byte index 4
    nack_frame = 5;
    launch(d2);
    wait_done(lat);
    chk("t4_latency", lat, 56*BIT);
    chk("t4_byte_cnt", bus.byte_cnt, 4);
    chk("t4_nack", bus.nack_err, 1);

    // start_tx and data_in churn while busy must not disturb the latched payload
    nack_frame = -1;
    s0 = start_cnt; b0 = rx.size();
    launch(da);
    chk("t5_nack_cleared", bus.nack_err, 0);
    chk("t5_byte_cnt_cleared", bus.byte_cnt, 0);
    repeat (500) @(negedge clk);
    bus.data_in  = dbv;
    bus.start_tx = 1'b1;
    @(negedge clk);
    bus.start_tx = 1'b0;
    repeat (2000) @(negedge clk);
    bus.start_tx = 1'b1;
    @(negedge clk);
    bus.start_tx = 1'b0;
    wait_done(lat);
    chk("t5_done_seen", bus.done, 1);
    chk("t5_starts", start_cnt - s0, 1);
    chk("t5_rx_count", rx.size() - b0, 34);
    for (int k = 0; k < DB; k++) chk($sformatf("t5_byte%0d", k), rx[b0+1+k], da[8*(DB-1-k) +: 8]);

    // start_tx during the done cycle is accepted
    bus.data_in  = d2;
    bus.start_tx = 1'b1;
    @(posedge clk);
    #1;
    bus.start_tx = 1'b0;
    chk("accept_on_done_busy", bus.busy, 1);

    // Reset mid-DATA aborts at once
    repeat (300) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t1_scl", scl, 1);
    chk("t1_sda", sda, 1);
    chk("t1_busy", bus.busy, 0);
    chk("t1_byte_cnt", bus.byte_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("t1_idle_scl", scl, 1);
    chk("t1_idle_busy", bus.busy, 0);
    s0 = start_cnt;
    launch(d2);
    repeat (2*BIT) @(posedge clk);
    #1;
    chk("t1_restart", start_cnt - s0, 1);
    chk("t1_restart_busy", bus.busy, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
